// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the registered instruction memory and buffers returned words in a 2-entry skid FIFO.
// Optional decode back-pressure counter is enabled by defining FETCH_STALL_CNT_EN.
module instruction_fetch #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [15:0]       stall_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight_q;
  logic [ADDR_W-1:0] fifo_pc   [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;

  always_comb begin
    inst_valid   = (count != 2'd0) & ~redirect_valid;
    pop          = inst_valid & inst_ready;
    push         = inflight_q & ~redirect_valid;
    // Words held or still returning after this edge; issuing only below 2 keeps the FIFO from overflowing.
    occupancy    = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue        = redirect_valid | (occupancy < 3'd2);
    imem_address = redirect_valid ? redirect_pc : pc;
    inst_data    = fifo_data[rd_ptr];
    inst_pc      = fifo_pc[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= ADDR_W'(RESET_PC);
      inflight_pc <= '0;
      inflight_q  <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      inflight_pc <= redirect_pc;
      inflight_q  <= 1'b1;
      pc          <= redirect_pc + ADDR_W'(1);
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= inflight_pc;
        fifo_data[wr_ptr] <= imem_data;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        inflight_q  <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(1);
      end else begin
        inflight_q  <= 1'b0;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((count != 2'd0) && !inst_ready && !redirect_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  always_comb stall_count = stall_q;
`else
  always_comb stall_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: random handshake/redirect traffic against a delivery-order model.
module tb_instruction_fetch;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 32;
  localparam int unsigned RPC = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic [15:0]   stall_count;

  logic [DW-1:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: next PC decode should see, cycles since the last flush, expected stall counter.
  int unsigned exp_pc;
  int unsigned age;
  int unsigned exp_stall;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_address];

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .stall_count    (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc    = RPC;
    age       = 1;
    exp_stall = 0;
  endtask

  task automatic do_reset();
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    reset          = 1'b0;
    #1;
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", {26'd0, inst_pc}, 32'd0);
    check("rst_stall", {16'd0, stall_count}, 32'd0);
    check("rst_addr", {26'd0, imem_address}, RPC);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [AW-1:0] rpc);
    bit ev;
    @(posedge clk);
    #1;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    ev = !rv && (age >= 2);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, ev});
    if (ev) begin
      check("inst_pc", {26'd0, inst_pc}, exp_pc);
      check("inst_data", inst_data, mem[exp_pc]);
    end
    if (rv) check("imem_address_redirect", {26'd0, imem_address}, {26'd0, rpc});
`ifdef FETCH_STALL_CNT_EN
    check("stall_count", {16'd0, stall_count}, exp_stall);
`else
    check("stall_count", {16'd0, stall_count}, 32'd0);
`endif
    if (ev && rdy) exp_pc = (exp_pc + 1) % 64;
    if (ev && !rdy && exp_stall < 65535) exp_stall++;
    if (rv) begin
      exp_pc = rpc;
      age    = 1;
    end else if (age < 2) begin
      age++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    model_reset();

    // Streaming from reset, long enough to wrap 63 -> 0.
    do_reset();
    for (int i = 0; i < 80; i++) step(1'b1, 1'b0, '0);

    // Back-pressure right at first valid; address must freeze at 2.
    do_reset();
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0);
      check("addr_hold", {26'd0, imem_address}, 32'd2);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Redirect to 40 while the FIFO holds 5 and 6.
    for (int i = 0; i < 100 && exp_pc != 5; i++) step(1'b1, 1'b0, '0);
    check("reach_pc5", exp_pc, 32'd5);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 6'd40);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);

    // Redirect to the top of memory, then back-to-back redirects.
    step(1'b1, 1'b1, 6'd63);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 6'd10);
    step(1'b0, 1'b1, 6'd20);
    step(1'b1, 1'b1, 6'd30);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Reset mid-stream with the FIFO full.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Random traffic, biased toward redirects near the wrap point.
    for (int i = 0; i < 1500; i++) begin
      logic          r;
      logic          v;
      logic [AW-1:0] t;
      r = ($urandom_range(0, 9) < 7);
      v = ($urandom_range(0, 99) < 8);
      t = ($urandom_range(0, 2) == 0) ? AW'(60 + $urandom_range(0, 3)) : AW'($urandom_range(0, 63));
      step(r, v, t);
    end

`ifdef FETCH_STALL_CNT_EN
    do_reset();
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, '0);
    check("stall_saturated", {16'd0, stall_count}, 32'd65535);
    step(1'b1, 1'b1, 6'd7);
    check("stall_kept_by_redirect", {16'd0, stall_count}, 32'd65535);
`else
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
